// File: rtl/logicnet_input_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : logicnet_input_packer_if
// Brief    : Feature stream in / packed vector out bundle for the input packer
// Revision : 1.0
// ============================================================================
interface logicnet_input_packer_if #(
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_W       = 16,
    parameter int QBITS        = 2
);
    logic                          s_valid;
    logic                          s_ready;
    logic [FEAT_W-1:0]             s_data;
    logic                          s_last;
    logic                          m_valid;
    logic                          m_ready;
    logic [NUM_FEATURES*QBITS-1:0] m_data;
    logic                          frame_err;
    logic [15:0]                   frame_count;

    // Environment side: feeds features and consumes vectors.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, frame_err, frame_count
    );

    // Packer side.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, frame_err, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/logicnet_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : logicnet_input_packer
// Brief    : Thermometer-quantizes a serial feature stream and packs one frame
//            into the flat layer-0 input vector behind a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module logicnet_input_packer #(
    parameter int                       NUM_FEATURES = 16,
    parameter int                       FEAT_W       = 16,
    parameter int                       QBITS        = 2,
    parameter logic signed [FEAT_W-1:0] T0           = -16'sd100,
    parameter logic signed [FEAT_W-1:0] T1           = 16'sd0,
    parameter logic signed [FEAT_W-1:0] T2           = 16'sd100
) (
    input  wire                    clk,
    input  wire                    rst,
    logicnet_input_packer_if.slave bus
);
    localparam int VEC_W = NUM_FEATURES * QBITS;
    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_FEATURES - 1);

    localparam logic [0:0] c_st_fill = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [VEC_W-1:0]  r_shadow;
    logic [VEC_W-1:0]  r_mdata;
    logic              r_mvalid;
    logic              r_frame_err;
    logic [15:0]       r_frame_count;

    logic              w_ge0;
    logic              w_ge1;
    logic              w_ge2;
    logic [QBITS-1:0]  w_code;
    logic [VEC_W-1:0]  w_vec_next;

    // Equality with a threshold counts as exceeding it.
    assign w_ge0  = $signed(bus.s_data) >= T0;
    assign w_ge1  = $signed(bus.s_data) >= T1;
    assign w_ge2  = $signed(bus.s_data) >= T2;
    assign w_code = QBITS'(w_ge0) + QBITS'(w_ge1) + QBITS'(w_ge2);

    always_comb begin
        w_vec_next = r_shadow;
        w_vec_next[r_idx*QBITS +: QBITS] = w_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_fill;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_mdata       <= '0;
            r_mvalid      <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                c_st_fill: begin
                    if (bus.s_valid) begin
                        r_shadow <= w_vec_next;
                        if (r_idx == c_idx_last) begin
                            r_idx <= '0;
                            if (bus.s_last) begin
                                r_mdata  <= w_vec_next;
                                r_mvalid <= 1'b1;
                                r_state  <= c_st_hold;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else if (bus.s_last) begin
                            // Early last: drop the partial frame and restart.
                            r_idx       <= '0;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_st_hold: begin
                    if (bus.m_ready) begin
                        r_mvalid      <= 1'b0;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_state       <= c_st_fill;
                    end
                end
                default: r_state <= c_st_fill;
            endcase
        end
    end

    assign bus.s_ready     = (r_state == c_st_fill) && !rst;
    assign bus.m_valid     = r_mvalid;
    assign bus.m_data      = r_mdata;
    assign bus.frame_err   = r_frame_err;
    assign bus.frame_count = r_frame_count;
endmodule
`default_nettype wire

// File: tb/tb_logicnet_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_logicnet_input_packer
// Brief    : Directed self-checking bench for logicnet_input_packer (4 features)
// Revision : 1.0
// ============================================================================
module tb_logicnet_input_packer;
    localparam int NF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    logicnet_input_packer_if #(.NUM_FEATURES(NF), .FEAT_W(16), .QBITS(2)) bus ();

    logicnet_input_packer #(.NUM_FEATURES(NF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Presents one beat from the falling edge and holds it until accepted.
    task automatic beat(input logic signed [15:0] d, input logic last);
        int n;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        n = 0;
        while (!bus.s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("beat_accept_timeout", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic frame(input logic signed [15:0] a, b, c, d);
        beat(a, 1'b0);
        beat(b, 1'b0);
        beat(c, 1'b0);
        beat(d, 1'b1);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_ready",     32'(bus.s_ready),     32'd0);
        check("rst_m_valid",     32'(bus.m_valid),     32'd0);
        check("rst_m_data",      32'(bus.m_data),      32'd0);
        check("rst_frame_count", 32'(bus.frame_count), 32'd0);
        check("rst_frame_err",   32'(bus.frame_err),   32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Nominal frame: codes 0,1,2,3
        frame(-16'sd200, -16'sd50, 16'sd50, 16'sd200);
        @(negedge clk);
        check("nom_m_valid", 32'(bus.m_valid), 32'd1);
        check("nom_m_data",  32'(bus.m_data),  32'hE4);
        check("nom_s_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        check("nom_m_valid_fall", 32'(bus.m_valid),     32'd0);
        check("nom_frame_count",  32'(bus.frame_count), 32'd1);
        check("nom_s_ready_back", 32'(bus.s_ready),     32'd1);
        check("nom_m_data_kept",  32'(bus.m_data),      32'hE4);

        // Threshold equality: codes 1,2,3,2
        frame(-16'sd100, 16'sd0, 16'sd100, 16'sd99);
        @(negedge clk);
        check("eq_m_data", 32'(bus.m_data), 32'hB9);
        @(negedge clk);
        check("eq_frame_count", 32'(bus.frame_count), 32'd2);

        // Backpressure with s_valid held: codes 3,0,2,1
        bus.m_ready = 1'b0;
        frame(16'sd150, -16'sd150, 16'sd0, -16'sd1);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'sd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_s_ready", 32'(bus.s_ready), 32'd0);
            check("bp_m_valid", 32'(bus.m_valid), 32'd1);
            check("bp_m_data",  32'(bus.m_data),  32'h63);
            check("bp_count",   32'(bus.frame_count), 32'd2);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("bp_s_ready_back", 32'(bus.s_ready),     32'd1);
        check("bp_m_valid_fall", 32'(bus.m_valid),     32'd0);
        check("bp_frame_count",  32'(bus.frame_count), 32'd3);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("bp_count_once", 32'(bus.frame_count), 32'd3);

        // Early last on the 2nd beat
        beat(16'sd200, 1'b0);
        beat(16'sd200, 1'b1);
        @(negedge clk);
        check("early_err",     32'(bus.frame_err), 32'd1);
        check("early_m_valid", 32'(bus.m_valid),   32'd0);
        @(negedge clk);
        check("early_err_pulse", 32'(bus.frame_err), 32'd0);
        frame(-16'sd1, 16'sd1, -16'sd101, 16'sd101);
        @(negedge clk);
        check("early_next_valid", 32'(bus.m_valid), 32'd1);
        check("early_next_data",  32'(bus.m_data),  32'hC9);
        @(negedge clk);
        check("early_next_count", 32'(bus.frame_count), 32'd4);

        // Missing last
        beat(16'sd200, 1'b0);
        beat(16'sd200, 1'b0);
        beat(16'sd200, 1'b0);
        beat(16'sd200, 1'b0);
        @(negedge clk);
        check("miss_err",     32'(bus.frame_err), 32'd1);
        check("miss_m_valid", 32'(bus.m_valid),   32'd0);
        @(negedge clk);
        check("miss_err_pulse", 32'(bus.frame_err),   32'd0);
        check("miss_count",     32'(bus.frame_count), 32'd4);
        frame(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        @(negedge clk);
        check("b2b_a_data", 32'(bus.m_data), 32'hAA);
        frame(-16'sd200, -16'sd200, 16'sd100, -16'sd200);
        @(negedge clk);
        check("b2b_b_data", 32'(bus.m_data), 32'h30);
        @(negedge clk);
        check("b2b_count", 32'(bus.frame_count), 32'd6);

        // Reset mid-frame
        beat(16'sd200, 1'b0);
        beat(16'sd200, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        check("mid_rst_m_valid", 32'(bus.m_valid),     32'd0);
        check("mid_rst_count",   32'(bus.frame_count), 32'd0);
        check("mid_rst_err",     32'(bus.frame_err),   32'd0);
        check("mid_rst_m_data",  32'(bus.m_data),      32'd0);
        rst = 1'b0;
        frame(-16'sd200, -16'sd200, -16'sd200, 16'sd200);
        @(negedge clk);
        check("post_rst_valid", 32'(bus.m_valid), 32'd1);
        check("post_rst_data",  32'(bus.m_data),  32'hC0);
        @(negedge clk);
        check("post_rst_count", 32'(bus.frame_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/logicnet_input_packer.md
# logicnet_input_packer

Upstream feeder for the first LogicNet layer of the cybernid classifier. It accepts raw signed feature words as a serial valid/ready stream, one feature per beat. Each feature is quantized to a QBITS-bit thermometer-count code against three shared thresholds. The codes are packed into the flat input vector consumed by the layer-0 neuron LUTs, and each completed vector is held under a valid/ready handshake.

## Interface
Parameters:
- NUM_FEATURES, 16, features per frame (beats per vector); ≥ 2
- FEAT_W, 16, signed raw feature width
- QBITS, 2, code width per feature; fixed at 2 (three thresholds)
- T0, -16'sd100, lowest threshold (signed, FEAT_W)
- T1, 16'sd0, middle threshold; T0 < T1 < T2 required
- T2, 16'sd100, highest threshold

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  feature beat valid
- s_ready  out  1  packer accepts a beat
- s_data  in  FEAT_W  signed feature value
- s_last  in  1  marks final beat of a frame
- m_valid  out  1  packed vector valid
- m_ready  in  1  downstream (layer 0) accepts vector
- m_data  out  NUM_FEATURES*QBITS  packed codes; feature i at bits [i*QBITS +: QBITS]
- frame_err  out  1  one-cycle pulse on framing error
- frame_count  out  16  count of vectors delivered; wraps at 65535→0

## Operation
- Quantizer (combinational on s_data, signed compare): code = (x>=T0)+(x>=T1)+(x>=T2), giving 0..3; equality counts as "exceeded".
- States: FILL (collecting beats), HOLD (vector presented).
- FILL: s_ready=1. On s_valid&&s_ready, write code into shadow register slot idx; idx counter 0..NUM_FEATURES-1.
  - idx==NUM_FEATURES-1 and s_last=1: copy the completed vector (with this beat's code) to m_data, set m_valid, clear idx, go to HOLD.
  - idx<NUM_FEATURES-1 and s_last=1 (early last): pulse frame_err, discard the partial frame, idx←0, stay in FILL.
  - idx==NUM_FEATURES-1 and s_last=0 (missing last): pulse frame_err, discard the frame, idx←0, stay in FILL. The next beat starts a new frame.
- HOLD: s_ready=0, m_valid=1, m_data stable. On m_ready: m_valid←0, frame_count+1, go to FILL.
- Shadow slots are not cleared between frames. m_data keeps the last delivered vector while m_valid=0.
- Upstream may hold s_valid high during HOLD. No beat is consumed until s_ready returns.

## Timing
- Reset (rst high at an edge): state FILL, idx 0, m_valid 0, m_data 0, shadow 0, frame_err 0, frame_count 0. s_ready is forced 0 while rst=1 and is 1 in the first cycle after deassertion.
- Reset mid-frame or mid-HOLD: the partial or held vector is lost and no frame_err is raised.
- Latency: final beat accepted at edge k → m_valid=1 and m_data valid after edge k (visible cycle k+1).
- Handshake at edge j (m_valid&&m_ready) → s_ready=1 from cycle j+1. The earliest next accepted beat is at edge j+1.
- Sustained throughput: NUM_FEATURES+1 cycles per vector with m_ready tied high.
- frame_err is registered and asserts in the cycle after the offending beat, for one cycle.
- frame_count updates in the same edge as the m_valid fall.
- m_ready while m_valid=0 is ignored.

## Test plan
Configuration for all scenarios: NUM_FEATURES=4, default thresholds.
- Nominal frame: beats -200,-50,50,200 with last on the 4th, m_ready=1 → m_data=8'b11100100 for one cycle starting the cycle after the 4th beat; frame_count=1.
- Threshold equality: beats -100,0,100,99 → codes 1,2,3,2 → m_data=8'b10111001.
- Backpressure: m_ready=0 for 5 cycles after a frame completes, with s_valid held high → s_ready=0 and m_data/m_valid stable throughout. After m_ready=1, s_ready=1 on the next cycle and frame_count increments exactly once.
- Early last: s_last on the 2nd beat → frame_err pulses one cycle, no m_valid. A following correct 4-beat frame delivers its own codes only.
- Missing last: 4 beats with s_last=0 → frame_err pulses once, no output. Back-to-back frames then resume correctly.
- Reset mid-frame: assert rst after 2 beats → m_valid=0, frame_count=0, s_ready=0 during reset. A full frame after reset yields the correct vector with no stale slots observable.
